// File: rtl/lsu_mem_interface.sv
// MEM-stage load/store unit: one request/response bus transaction per access, pipeline stall, load formatting.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module lsu_mem_interface #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  is_unsigned,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  misalign_fault,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_wstrb,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [31:0]           bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [31:0]             load_q, load_d;
  logic                    fault_q, fault_d;

  logic                    access;
  logic                    trap;
  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic [31:0]             lane_wdata;
  logic [3:0]              lane_wstrb;

  assign access = mem_valid & (mem_read | mem_write);

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   fmt_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   fmt_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
      2'b10:   fmt_load = rdata;
      default: fmt_load = 32'h0;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((mem_size == 2'b01) & mem_addr[0]) | ((mem_size == 2'b10) & (|mem_addr[1:0]));
`else
  assign trap = 1'b0;
`endif

  // Forcing natural alignment is harmless in trap mode: trapped accesses never reach the bus.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path can infer a latch.
    aligned_addr = mem_addr;
    lane_wdata   = 32'h0;
    lane_wstrb   = 4'b0000;
    case (mem_size)
      2'b00: begin
        lane_wstrb = 4'b0001 << mem_addr[1:0];
        lane_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        aligned_addr[0] = 1'b0;
        lane_wstrb      = 4'b0011 << {mem_addr[1], 1'b0};
        lane_wdata      = {2{store_data[15:0]}};
      end
      2'b10: begin
        aligned_addr[1:0] = 2'b00;
        lane_wstrb        = 4'b1111;
        lane_wdata        = store_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    load_d  = load_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          addr_d  = aligned_addr;
          size_d  = mem_size;
          uns_d   = is_unsigned;
          we_d    = mem_write;
          wdata_d = lane_wdata;
          wstrb_d = lane_wstrb;
          fault_d = trap;
          if (trap || mem_size == 2'b11) begin
            state_d = DONE;
            // A reserved-size load completes immediately with zero data.
            if (!trap && !mem_write) load_d = 32'h0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ:  if (bus_gnt) state_d = we_q ? DONE : RESP;
      RESP: begin
        if (bus_rvalid) begin
          load_d  = fmt_load(bus_rdata, addr_q[1:0], size_q, uns_q);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        fault_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because every bus and load output must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      load_q  <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      load_q  <= load_d;
      fault_q <= fault_d;
    end
  end

  assign stall      = access & (state_q != DONE);
  assign bus_req    = (state_q == REQ);
  assign bus_we     = we_q;
  assign bus_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;
  assign load_data  = load_q;
  assign load_valid = (state_q == DONE) & ~we_q & ~fault_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_fault = (state_q == DONE) & fault_q;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: doc/lsu_mem_interface.md
Name: lsu_mem_interface

Overview:
- Load/store unit in the MEM stage. It consumes the decoder's memory controls (mem_to_reg, store_enable, mem_size, is_unsigned) together with the ALU-computed address and the store data.
- Runs each access as a multi-cycle request/response transaction on a word-wide data bus.
- Stalls the pipeline while an access is in flight and returns sign- or zero-extended load data for writeback.

Parameters:
- ADDR_WIDTH, 32, byte-address width of mem_addr and bus_addr. Data width is fixed at 32.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM-stage instruction valid
- mem_read  in  1  load request (decoder mem_to_reg)
- mem_write  in  1  store request (decoder store_enable)
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- is_unsigned  in  1  zero-extend load when 1
- mem_addr  in  ADDR_WIDTH  byte address from ALU
- store_data  in  32  rs2 value
- stall  out  1  hold pipeline (combinational)
- load_data  out  32  formatted load result
- load_valid  out  1  one-cycle pulse when load_data is updated
- misalign_fault  out  1  one-cycle pulse (only with the optional feature)
- bus_req  out  1  bus request
- bus_we  out  1  1 write, 0 read
- bus_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- bus_wdata  out  32  lane-replicated write data
- bus_wstrb  out  4  byte enables
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, load_data, load_valid, misalign_fault. Reset mid-transaction drops bus_req immediately. Any later bus_gnt/bus_rvalid is ignored until a new request is issued.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If mem_valid & (mem_read | mem_write), latch addr/size/unsigned/op and go to REQ.
  - If mem_write=1, the store is taken and mem_read is ignored.
  - mem_size=11 goes directly to DONE with no bus activity; a load then returns load_data=0.
- REQ:
  - bus_req=1, with bus_we/addr/wdata/wstrb held stable until bus_gnt.
  - On bus_gnt, drop bus_req. A write goes to DONE; a read goes to RESP.
- RESP:
  - Wait for bus_rvalid (earliest one cycle after gnt).
  - On rvalid, register the formatted load_data and go to DONE.
- DONE:
  - Pulse load_valid=1 for one cycle (loads only), then go to IDLE.
- stall = mem_valid & (mem_read | mem_write) & (state != DONE). So the pipeline advances exactly in the DONE cycle. A new op presented in the following cycle is accepted from IDLE.
- Latency with gnt in REQ's first cycle:
  - Store: 2 stall cycles.
  - Load with rvalid the cycle after gnt: 3 stall cycles.
  - Unbounded bus waits extend the stall.
- bus_addr = {mem_addr[ADDR_WIDTH-1:2], 2'b00}.
- Store lanes:
  - Byte: wstrb = 0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - Half: wstrb = 0011 << {addr[1],1'b0}; wdata = {2{sd[15:0]}}.
  - Word: wstrb = 1111; wdata = sd.
- Load formatting: select byte lane addr[1:0] or half lane addr[1]. Sign-extend from bit 7/15 unless is_unsigned, in which case zero-extend. Word loads pass through.
- load_data holds its value until the next load completes.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1 or a word access with addr[1:0]!=0 is misaligned.
  - IDLE goes directly to DONE with no bus request and pulses misalign_fault for one cycle in DONE.
  - load_valid stays 0 and load_data is unchanged.
- Undefined:
  - misalign_fault is tied 0.
  - The offending low address bits are forced to natural alignment: half clears addr[0], word clears addr[1:0].
  - The access then proceeds normally.

Test Plan:
- SW addr=0x104, sd=0xDEADBEEF, gnt on first REQ cycle -> bus_addr=0x104, wstrb=1111, wdata=0xDEADBEEF, stall high exactly 2 cycles, no load_valid.
- SB addr=0x203, sd=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5, bus_addr=0x200.
- LB addr=0x301, rdata=0x0000_80_00 vs LBU same -> load_data=0xFFFFFF80 vs 0x00000080; load_valid one pulse; 3 stall cycles with rvalid the cycle after gnt.
- LH addr=0x402, rdata=0x8001_1234, gnt delayed 3 cycles -> bus_req held with stable addr 0x400, load_data=0xFFFF8001, stall=6 cycles.
- Back-to-back SW then LW with no gap -> second op accepted the cycle after DONE; exactly one bus_req per op.
- rst_n low during RESP, then rvalid arrives -> state IDLE, all outputs 0, load_valid stays 0. Also LW addr=0x102 -> with LSU_MISALIGN_TRAP_EN: fault pulse and no bus_req; without: bus_addr=0x100 and a normal load.
